memory_accessor_pipelined: RTL and testbench

Parametrised successor to the single-transaction memory accessor. Accepts OPCODE_MA packets (MA_REF / MA_SET), issues memory requests, and returns one worker result per memory response. Up to DEPTH requests may be in flight, tracked by an in-order context FIFO. Sits between the packet dispatcher (PC channel) and the worker-result return path (WR channel), with the memory port on the other side.

---
 rtl/memory_accessor_pipelined.sv | 180 ++++++++++++++++++
 tb/tb_memory_accessor_pipelined.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_accessor_pipelined.sv
// memory_accessor_pipelined
//   Takes memory-access packets (MA_REF read / MA_SET write), issues one memory
//   request per legal packet, and returns one worker result per memory
//   response. Up to DEPTH requests may be in flight. The destination context
//   of each request waits in an in-order FIFO until its response comes back.
//
// Ports
//   CLK, RST                       clock, synchronous active-high reset
//   RECEIVE_PC_VALID/DATA/READY    packet channel from the dispatcher
//   MEM_SEND_ADDR_VALID/ADDR       memory request (DATA_VALID=1 means write)
//   MEM_SEND_DATA_VALID/DATA       write flag and write data
//   MEM_SEND_READY                 memory accepts the request
//   MEM_RECEIVE_VALID/DATA/READY   memory response channel
//   SEND_WR_VALID/DATA/READY       worker result {dest_option, dest_addr, color, data}
//   OUTSTANDING                    requests in flight (context FIFO count)
//   ERR_OP                         sticky flag, unsupported subop seen
//
// Packet layout, MSB first (181 bits):
//   opcode[7:0] subop[9:0] data1 data2 data3 data4 dest_option[2:0]
//   dest_addr[15:0] color[15:0]
module memory_accessor_pipelined #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_SHIFT = 0,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  localparam int unsigned PACKET_WIDTH        = 181,
  localparam int unsigned WORKER_RESULT_WIDTH = 67,
  localparam int unsigned AW                  = $clog2(DEPTH)
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           RECEIVE_PC_VALID,
  input  logic [PACKET_WIDTH-1:0]        RECEIVE_PC_DATA,
  output logic                           RECEIVE_PC_READY,
  output logic                           MEM_SEND_ADDR_VALID,
  output logic [31:0]                    MEM_SEND_ADDR,
  output logic                           MEM_SEND_DATA_VALID,
  output logic [31:0]                    MEM_SEND_DATA,
  input  logic                           MEM_SEND_READY,
  input  logic                           MEM_RECEIVE_VALID,
  input  logic [31:0]                    MEM_RECEIVE_DATA,
  output logic                           MEM_RECEIVE_READY,
  output logic                           SEND_WR_VALID,
  output logic [WORKER_RESULT_WIDTH-1:0] SEND_WR_DATA,
  input  logic                           SEND_WR_READY,
  output logic [AW:0]                    OUTSTANDING,
  output logic                           ERR_OP
);

  localparam logic [9:0] MA_REF = 10'd0;
  localparam logic [9:0] MA_SET = 10'd1;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [9:0]  subop;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] data3;
    logic [31:0] data4;
    logic [2:0]  dest_option;
    logic [15:0] dest_addr;
    logic [15:0] color;
  } pkt_t;

  typedef struct packed {
    logic [2:0]  dest_option;
    logic [15:0] dest_addr;
    logic [15:0] color;
  } ctx_t;

  pkt_t pkt;
  ctx_t pkt_ctx;
  assign pkt     = pkt_t'(RECEIVE_PC_DATA);
  assign pkt_ctx = '{dest_option: pkt.dest_option, dest_addr: pkt.dest_addr, color: pkt.color};

  // The dispatcher only routes memory-access packets here, so the opcode is
  // not re-decoded; data3/data4 carry nothing for this unit.
  logic unused_pkt;
  assign unused_pkt = ^{pkt.opcode, pkt.data3, pkt.data4};

  // Registered reset keeps PC_READY low for the first cycle after release.
  logic rst_q;
  always_ff @(posedge CLK) rst_q <= RST;

  // ---------------------------------------------------------------- state
  logic          req_vld_q, req_vld_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic          req_we_q, req_we_d;
  logic [31:0]   req_wdata_q, req_wdata_d;
  logic          wr_vld_q, wr_vld_d;
  logic [WORKER_RESULT_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic          err_q, err_d;
  ctx_t          ctx_q [DEPTH];

  logic full, empty, legal, is_set, pc_fire, push, pop;

  // Pointers carry a wrap bit: equal low bits with differing wrap bits = full.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // Full is taken from registered pointers only: a same-cycle pop does not
  // open a slot for a same-cycle accept.
  assign RECEIVE_PC_READY  = !rst_q && !full && (!req_vld_q || MEM_SEND_READY);
  assign MEM_RECEIVE_READY = !empty && (!wr_vld_q || SEND_WR_READY);

  assign is_set  = (pkt.subop == MA_SET);
  assign legal   = (pkt.subop == MA_REF) || is_set;
  assign pc_fire = RECEIVE_PC_VALID && RECEIVE_PC_READY;
  assign push    = pc_fire && legal;
  assign pop     = MEM_RECEIVE_VALID && MEM_RECEIVE_READY;

  always_comb begin
    req_vld_d   = req_vld_q;
    req_addr_d  = req_addr_q;
    req_we_d    = req_we_q;
    req_wdata_d = req_wdata_q;
    wr_vld_d    = wr_vld_q;
    wr_data_d   = wr_data_q;
    wptr_d      = wptr_q + (AW+1)'(push);
    rptr_d      = rptr_q + (AW+1)'(pop);
    err_d       = err_q || (pc_fire && !legal);

    // Accept only happens when the output register is empty or draining,
    // so a new request may overwrite it directly.
    if (push) begin
      req_vld_d   = 1'b1;
      req_addr_d  = BASE_ADDR + (pkt.data1 << ADDR_SHIFT);
      req_we_d    = is_set;
      req_wdata_d = is_set ? pkt.data2 : 32'h0;
    end else if (MEM_SEND_READY) begin
      req_vld_d   = 1'b0;
    end

    if (pop) begin
      wr_vld_d  = 1'b1;
      wr_data_d = {ctx_q[rptr_q[AW-1:0]], MEM_RECEIVE_DATA};
    end else if (SEND_WR_READY) begin
      wr_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      req_vld_q   <= 1'b0;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      wr_vld_q    <= 1'b0;
      wr_data_q   <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      req_vld_q   <= req_vld_d;
      req_addr_q  <= req_addr_d;
      req_we_q    <= req_we_d;
      req_wdata_q <= req_wdata_d;
      wr_vld_q    <= wr_vld_d;
      wr_data_q   <= wr_data_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      err_q       <= err_d;
    end
  end

  // Context storage needs no reset: pointers define which entries are live.
  always_ff @(posedge CLK) begin
    if (!RST && push) ctx_q[wptr_q[AW-1:0]] <= pkt_ctx;
  end

  assign MEM_SEND_ADDR_VALID = req_vld_q;
  assign MEM_SEND_ADDR       = req_addr_q;
  assign MEM_SEND_DATA_VALID = req_we_q;
  assign MEM_SEND_DATA       = req_wdata_q;
  assign SEND_WR_VALID       = wr_vld_q;
  assign SEND_WR_DATA        = wr_data_q;
  assign OUTSTANDING         = wptr_q - rptr_q;
  assign ERR_OP              = err_q;

endmodule

// File: tb/tb_memory_accessor_pipelined.sv
// Bench for memory_accessor_pipelined. Three instances share all inputs and
// differ only in address formation (shift 2 / base 0x1000_0000, shift 0 /
// base 0, shift 0 / base 1); handshakes are taken from instance 0.
module tb_memory_accessor_pipelined;
  localparam int DEPTH = 4;
  localparam logic [9:0] MA_REF    = 10'd0;
  localparam logic [9:0] MA_SET    = 10'd1;
  localparam logic [7:0] OPCODE_MA = 8'h05;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic pc_valid = 1'b0;
  logic [180:0] pc_data = '0;
  logic msr = 1'b0;
  logic mrv = 1'b0;
  logic [31:0] mrd = '0;
  logic wr_ready = 1'b0;

  logic pc_ready [3];
  logic mav [3];
  logic [31:0] maddr [3];
  logic mdv [3];
  logic [31:0] mdat [3];
  logic mrr [3];
  logic wrv [3];
  logic [66:0] wrd [3];
  logic [2:0] outst [3];
  logic err [3];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    memory_accessor_pipelined #(
      .DEPTH(DEPTH),
      .ADDR_SHIFT(g == 0 ? 2 : 0),
      .BASE_ADDR(g == 0 ? 32'h1000_0000 : (g == 2 ? 32'h1 : 32'h0))
    ) u_dut (
      .CLK(CLK), .RST(RST),
      .RECEIVE_PC_VALID(pc_valid), .RECEIVE_PC_DATA(pc_data), .RECEIVE_PC_READY(pc_ready[g]),
      .MEM_SEND_ADDR_VALID(mav[g]), .MEM_SEND_ADDR(maddr[g]),
      .MEM_SEND_DATA_VALID(mdv[g]), .MEM_SEND_DATA(mdat[g]), .MEM_SEND_READY(msr),
      .MEM_RECEIVE_VALID(mrv), .MEM_RECEIVE_DATA(mrd), .MEM_RECEIVE_READY(mrr[g]),
      .SEND_WR_VALID(wrv[g]), .SEND_WR_DATA(wrd[g]), .SEND_WR_READY(wr_ready),
      .OUTSTANDING(outst[g]), .ERR_OP(err[g])
    );
  end

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [31:0] a0, a1, a2;
    logic        we;
    logic [31:0] wd;
  } req_t;

  req_t        req_q [$];   // requests accepted, not yet taken by memory
  logic [34:0] ctx_q [$];   // contexts of requests in flight
  logic [66:0] wr_q  [$];   // results owed on the WR channel
  int   mem_pend = 0;       // requests memory holds without a response yet
  int   accepted = 0;
  int   ncmp = 0, nfail = 0;
  logic err_m = 1'b0;
  logic pc_f, mr_f;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [180:0] mk_pkt(input logic [9:0] sub, input logic [31:0] d1, d2,
                                          input logic [2:0] dopt, input logic [15:0] da, col);
    return {OPCODE_MA, sub, d1, d2, 32'($urandom), 32'($urandom), dopt, da, col};
  endfunction

  function automatic logic [180:0] rand_pkt();
    return mk_pkt($urandom_range(0, 1) != 0 ? MA_SET : MA_REF, $urandom, $urandom,
                  3'($urandom), 16'($urandom), 16'($urandom));
  endfunction

  // Called at the falling edge: checks current outputs, then books the
  // transfers that the coming rising edge will perform.
  task automatic observe();
    logic mq_f, wr_f;
    logic [9:0] sub;
    logic [31:0] d1, d2;
    req_t r;
    check("outstanding", 128'(outst[0]), 128'(ctx_q.size()));
    check("err_op", 128'(err[0]), 128'(err_m));
    if (ctx_q.size() == DEPTH) check("full_blocks_pc", 128'(pc_ready[0]), 128'(0));
    pc_f = pc_valid && pc_ready[0];
    mq_f = mav[0] && msr;
    mr_f = mrv && mrr[0];
    wr_f = wrv[0] && wr_ready;
    if (mq_f) begin
      if (req_q.size() == 0) check("spurious_req", 128'(mav[0]), 128'(0));
      else begin
        r = req_q.pop_front();
        check("req_addr0", 128'(maddr[0]), 128'(r.a0));
        check("req_addr1", 128'(maddr[1]), 128'(r.a1));
        check("req_addr2", 128'(maddr[2]), 128'(r.a2));
        check("req_we", 128'(mdv[0]), 128'(r.we));
        check("req_wdata", 128'(mdat[0]), 128'(r.wd));
        mem_pend++;
      end
    end
    if (wr_f) begin
      if (wr_q.size() == 0) check("spurious_wr", 128'(wrv[0]), 128'(0));
      else check("wr_data", 128'(wrd[0]), 128'(wr_q.pop_front()));
    end
    if (mr_f) begin
      if (ctx_q.size() == 0) check("spurious_resp_ready", 128'(mrr[0]), 128'(0));
      else wr_q.push_back({ctx_q.pop_front(), mrd});
      mem_pend--;
    end
    if (pc_f) begin
      accepted++;
      sub = pc_data[172:163];
      d1  = pc_data[162:131];
      d2  = pc_data[130:99];
      if (sub == MA_REF || sub == MA_SET) begin
        r.a0 = 32'h1000_0000 + d1 * 32'd4;
        r.a1 = d1;
        r.a2 = d1 + 32'd1;
        r.we = (sub == MA_SET);
        r.wd = (sub == MA_SET) ? d2 : 32'h0;
        req_q.push_back(r);
        ctx_q.push_back(pc_data[34:0]);
      end else begin
        err_m = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    observe();
    @(posedge CLK);
    #1;
    if (pc_f) pc_valid = 1'b0;
    if (mr_f) mrv = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    msr = 1'b1;
    wr_ready = 1'b1;
    while ((pc_valid || req_q.size() != 0 || ctx_q.size() != 0 || wr_q.size() != 0 ||
            mrv || mem_pend != 0) && n < 500) begin
      if (!mrv && mem_pend > 0) begin mrv = 1'b1; mrd = $urandom; end
      tick();
      n++;
    end
    check("drain_in_time", 128'(n < 500), 128'(1));
    check("idle_mav", 128'(mav[0]), 128'(0));
    check("idle_wrv", 128'(wrv[0]), 128'(0));
  endtask

  initial begin
    int acc0, k, n;
    logic [31:0] r32;

    // Reset with a packet already offered.
    RST = 1'b1;
    pc_data = mk_pkt(MA_REF, 32'h0000_0010, 32'h0, 3'd5, 16'hABCD, 16'h1234);
    pc_valid = 1'b1;
    msr = 1'b1;
    wr_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_pc_ready", 128'(pc_ready[0]), 128'(0));
    check("rst_mav", 128'(mav[0]), 128'(0));
    check("rst_wrv", 128'(wrv[0]), 128'(0));
    check("rst_mrr", 128'(mrr[0]), 128'(0));
    check("rst_outst", 128'(outst[0]), 128'(0));
    check("rst_err", 128'(err[0]), 128'(0));
    check("rst_addr", 128'(maddr[0]), 128'(0));
    check("rst_wrd", 128'(wrd[0]), 128'(0));
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("post_rst_pc_ready", 128'(pc_ready[0]), 128'(1));

    // Single MA_REF.
    tick();
    check("ref_mav", 128'(mav[0]), 128'(1));
    check("ref_addr_shift2", 128'(maddr[0]), 128'(32'h1000_0040));
    check("ref_dv", 128'(mdv[0]), 128'(0));
    check("ref_outst", 128'(outst[0]), 128'(1));
    tick();
    mrv = 1'b1;
    mrd = 32'hDEAD_BEEF;
    tick();
    check("ref_wrv", 128'(wrv[0]), 128'(1));
    check("ref_wr", 128'(wrd[0]), 128'({3'd5, 16'hABCD, 16'h1234, 32'hDEAD_BEEF}));
    tick();

    // MA_SET.
    pc_data = mk_pkt(MA_SET, 32'd5, 32'h1234_5678, 3'd2, 16'h0042, 16'h7777);
    pc_valid = 1'b1;
    tick();
    check("set_addr", 128'(maddr[1]), 128'(32'd5));
    check("set_dv", 128'(mdv[0]), 128'(1));
    check("set_data", 128'(mdat[0]), 128'(32'h1234_5678));
    tick();
    r32 = $urandom;
    mrv = 1'b1;
    mrd = r32;
    tick();
    check("set_wr_data", 128'(wrd[0][31:0]), 128'(r32));
    drain();

    // Fill: five packets, no responses.
    acc0 = accepted;
    k = 0;
    repeat (10) begin
      if (!pc_valid && k < 5) begin pc_data = rand_pkt(); pc_valid = 1'b1; k++; end
      tick();
    end
    check("fill_accepted", 128'(accepted - acc0), 128'(4));
    check("fill_pc_ready", 128'(pc_ready[0]), 128'(0));
    check("fill_outst", 128'(outst[0]), 128'(4));
    n = 0;
    while ((accepted - acc0 < 5 || ctx_q.size() != 0 || wr_q.size() != 0) && n < 100) begin
      if (!mrv && mem_pend > 0) begin mrv = 1'b1; mrd = $urandom; end
      tick();
      n++;
    end
    check("fill_fifth_accepted", 128'(accepted - acc0), 128'(5));
    drain();

    // Random traffic with backpressure on all channels.
    k = 0;
    n = 0;
    while (k < 100 && n < 5000) begin
      if (!pc_valid && $urandom_range(0, 3) != 0) begin pc_data = rand_pkt(); pc_valid = 1'b1; k++; end
      msr = ($urandom_range(0, 3) != 0);
      wr_ready = ($urandom_range(0, 2) != 0);
      if (!mrv && mem_pend > 0 && $urandom_range(0, 1) != 0) begin mrv = 1'b1; mrd = $urandom; end
      tick();
      check("outst_le_depth", 128'(outst[0] <= 3'(DEPTH)), 128'(1));
      n++;
    end
    drain();

    // Unsupported subop, then address wrap.
    pc_data = mk_pkt(10'h3FF, $urandom, $urandom, 3'd1, 16'h1, 16'h2);
    pc_valid = 1'b1;
    tick();
    check("illegal_err", 128'(err[0]), 128'(1));
    check("illegal_no_req", 128'(mav[0]), 128'(0));
    check("illegal_no_push", 128'(outst[0]), 128'(0));
    pc_data = mk_pkt(MA_REF, 32'hFFFF_FFFF, 32'h0, 3'd3, 16'h3, 16'h4);
    pc_valid = 1'b1;
    tick();
    check("wrap_addr_base1", 128'(maddr[2]), 128'(32'h0));
    check("wrap_addr_shift2", 128'(maddr[0]), 128'(32'h0FFF_FFFC));
    drain();
    check("err_sticky", 128'(err[0]), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
